// File: rtl/aes_inv_cipher_ctrl_if.sv
// aes_inv_cipher_ctrl_if: ciphertext input, plaintext output and round-key read port
interface aes_inv_cipher_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   modport master (output in_valid, in_data, rk_data, out_ready,
                   input  in_ready, rk_idx, out_valid, out_data, busy);
   modport slave  (input  in_valid, in_data, rk_data, out_ready,
                   output in_ready, rk_idx, out_valid, out_data, busy);
endinterface

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES-128 decryption, one inverse round per clock
module inv_mix_columns (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   // 14*a ^ 11*b ^ 13*c ^ 9*d in GF(2^8)
   function automatic logic [7:0] mix(input logic [7:0] a, b, c, d);
      logic [7:0] a2, a4, a8, b2, b8, c4, c8, d8;
      a2 = xt(a); a4 = xt(a2); a8 = xt(a4);
      b2 = xt(b); b8 = xt(xt(b2));
      c4 = xt(xt(c)); c8 = xt(c4);
      d8 = xt(xt(xt(d)));
      return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
   endfunction
   always_comb begin
      dout = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            dout[32*c+8*r +: 8] = mix(din[32*c+8*r +: 8], din[32*c+8*((r+1)%4) +: 8],
                                      din[32*c+8*((r+2)%4) +: 8], din[32*c+8*((r+3)%4) +: 8]);
   end
endmodule

module aes_inv_cipher_ctrl (
   input  logic               clk,
   input  logic               rst_n,
   aes_inv_cipher_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
   // inverse S-box, entry 0 in the top byte
   localparam logic [2047:0] inv_sbox_tbl = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   state_t       state, state_d;
   logic [3:0]   rnd, rnd_d;
   logic [127:0] st, st_d, ark, imc;
   function automatic logic [7:0] isb(input logic [7:0] b);
      return inv_sbox_tbl[{~b, 3'b000} +: 8];
   endfunction
   // InvShiftRows + InvSubBytes + AddRoundKey, shared by ROUND and FINAL
   always_comb begin
      ark = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            ark[32*c+8*r +: 8] = isb(st[32*((c-r+4)%4)+8*r +: 8]) ^ bus.rk_data[32*c+8*r +: 8];
   end
   inv_mix_columns u_imc (.din(ark), .dout(imc));
   always_comb begin
      state_d = state;
      rnd_d   = rnd;
      st_d    = st;
      case (state)
         IDLE: if (bus.in_valid) begin
            st_d    = bus.in_data ^ bus.rk_data;
            rnd_d   = 4'd9;
            state_d = ROUND;
         end
         ROUND: begin
            st_d = imc;
            if (rnd == 4'd1) state_d = FINAL;
            else rnd_d = rnd - 4'd1;
         end
         FINAL: begin
            st_d    = ark;
            state_d = DONE;
         end
         default: state_d = bus.out_ready ? IDLE : DONE;
      endcase
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.out_data  = st;
   assign bus.rk_idx    = state == ROUND ? rnd : state == FINAL ? 4'd0 : 4'd10;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         rnd   <= '0;
         st    <= '0;
      end else begin
         state <= state_d;
         rnd   <= rnd_d;
         st    <= st_d;
      end
endmodule
